// File: rtl/led_pkg.sv
// Shared types for the LED stream receiver: colour word and receive FSM states.
package led_pkg;
  localparam int unsigned COLOR_W = 24;
  typedef logic [COLOR_W-1:0] rgb_t;
  typedef enum logic {IDLE, RECV} rx_state_t;
endpackage

// File: rtl/sync_edge_detect.sv
// Brings the asynchronous LED clock/data into the clk domain and strobes on
// qualified LED-clock rising edges.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  input  logic d_in,
  output logic edge_stb,
  output logic data_sync
);
  logic       clk_s1, clk_s2, clk_prev;
  logic       d_s1, d_s2;
  logic       armed;
  logic [1:0] fill;

  // Arming waits until the synchroniser holds a real post-reset sample, so a
  // line held high through reset cannot masquerade as a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1   <= 1'b0;
      clk_s2   <= 1'b0;
      clk_prev <= 1'b0;
      d_s1     <= 1'b0;
      d_s2     <= 1'b0;
      armed    <= 1'b0;
      fill     <= '0;
    end else begin
      clk_s1   <= clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      d_s1     <= d_in;
      d_s2     <= d_s1;
      if (fill != 2'd2) fill <= fill + 2'd1;
      if (fill == 2'd2 && !clk_s2) armed <= 1'b1;
    end
  end

  assign edge_stb  = armed && clk_s2 && !clk_prev;
  assign data_sync = d_s2;
endmodule

// File: rtl/led_stream_receiver.sv
// Two-wire LED stream receiver: rebuilds 24-bit colours, stores one frame and
// reports frame length and framing errors after each idle gap.
module led_stream_receiver
  import led_pkg::*;
#(
  parameter int unsigned LEDS         = 50,
  parameter int unsigned FREQ         = 12_500_000,
  parameter int unsigned LATCH_CYCLES = FREQ / 2000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clkIn,
  input  logic                       dIn,
  output logic [COLOR_W-1:0]         pixel,
  output logic [$clog2(LEDS)-1:0]    pixelIdx,
  output logic                       pixel_v,
  output logic                       frameDone,
  output logic [$clog2(LEDS+1)-1:0]  frameLen,
  output logic                       partialErr,
  output logic                       overflowErr,
  output logic                       busy,
  input  logic [$clog2(LEDS)-1:0]    rdAddr,
  output logic [COLOR_W-1:0]         rdData
);
  localparam int unsigned IW = $clog2(LEDS);
  localparam int unsigned CW = $clog2(LEDS + 1);
  localparam int unsigned TW = $clog2(LATCH_CYCLES + 1);
  localparam logic [CW-1:0] LEDS_C   = CW'(LEDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(LEDS - 1);
  localparam logic [TW-1:0] IDLE_MAX = TW'(LATCH_CYCLES - 1);

  rx_state_t     state, state_nxt;
  logic          edge_stb, data_sync;
  rgb_t          shreg, shifted;
  logic [4:0]    bit_cnt;
  logic [CW-1:0] led_cnt;
  logic [TW-1:0] idle_cnt;
  logic          overflow;
  logic          pix_done, room, frame_end;
  rgb_t          mem [LEDS];

  sync_edge_detect u_sync (
    .clk       (clk),
    .rst       (rst),
    .clk_in    (clkIn),
    .d_in      (dIn),
    .edge_stb  (edge_stb),
    .data_sync (data_sync)
  );

  // An edge on the terminal idle count keeps the frame alive.
  assign shifted   = {shreg[COLOR_W-2:0], data_sync};
  assign pix_done  = edge_stb && (bit_cnt == 5'd23);
  assign room      = (led_cnt < LEDS_C);
  assign frame_end = (state == RECV) && !edge_stb && (idle_cnt == IDLE_MAX);
  assign busy      = (state == RECV);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (edge_stb) state_nxt = RECV;
      RECV:    if (frame_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      led_cnt     <= '0;
      idle_cnt    <= '0;
      overflow    <= 1'b0;
      pixel       <= '0;
      pixelIdx    <= '0;
      pixel_v     <= 1'b0;
      frameDone   <= 1'b0;
      frameLen    <= '0;
      partialErr  <= 1'b0;
      overflowErr <= 1'b0;
    end else begin
      pixel_v   <= 1'b0;
      frameDone <= 1'b0;
      if (edge_stb) begin
        shreg    <= shifted;
        idle_cnt <= '0;
        if (pix_done) begin
          bit_cnt  <= '0;
          pixel    <= shifted;
          pixelIdx <= room ? IW'(led_cnt) : LAST_IDX;
          pixel_v  <= 1'b1;
          if (room) led_cnt  <= led_cnt + 1'b1;
          else      overflow <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end else if (frame_end) begin
        frameDone   <= 1'b1;
        frameLen    <= led_cnt;
        partialErr  <= (bit_cnt != '0);
        overflowErr <= overflow;
        bit_cnt     <= '0;
        led_cnt     <= '0;
        idle_cnt    <= '0;
        overflow    <= 1'b0;
      end else if (state == RECV) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pix_done && room) mem[IW'(led_cnt)] <= shifted;
  end

  always_ff @(posedge clk) begin
    if (rst)                      rdData <= '0;
    else if (32'(rdAddr) < LEDS)  rdData <= mem[rdAddr];
    else                          rdData <= '0;
  end
endmodule

// File: tb/tb_led_stream_receiver.sv
// Scoreboard bench for led_stream_receiver: frames are built from colour lists,
// expected pixels/frame results are queued, and a monitor checks DUT strobes.
module tb_led_stream_receiver;
  localparam int unsigned LEDS  = 50;
  localparam int unsigned FREQ  = 2_000_000;
  localparam int unsigned LATCH = FREQ / 2000;

  logic        clk = 1'b0, rst = 1'b1, clkIn = 1'b0, dIn = 1'b0;
  logic [5:0]  rdAddr = '0;
  logic [23:0] pixel, rdData;
  logic [5:0]  pixelIdx, frameLen;
  logic        pixel_v, frameDone, partialErr, overflowErr, busy;

  always #5 clk = ~clk;

  led_stream_receiver #(.LEDS(LEDS), .FREQ(FREQ)) dut (
    .clk(clk), .rst(rst), .clkIn(clkIn), .dIn(dIn),
    .pixel(pixel), .pixelIdx(pixelIdx), .pixel_v(pixel_v),
    .frameDone(frameDone), .frameLen(frameLen), .partialErr(partialErr),
    .overflowErr(overflowErr), .busy(busy), .rdAddr(rdAddr), .rdData(rdData)
  );

  typedef struct { logic [23:0] val; int unsigned idx; } px_t;
  typedef struct { int unsigned len; bit part; bit ovf; } fr_t;

  px_t         exp_px[$];
  fr_t         exp_fr[$];
  px_t         ep;
  fr_t         ef;
  logic [23:0] mdl_buf [LEDS];
  logic [23:0] send_q[$];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // One LED-clock bit: data set while low, rising edge after `low` cycles.
  task automatic send_bit(input logic b, input int unsigned low);
    dIn = b; clkIn = 1'b0; tick(low);
    clkIn = 1'b1; tick(4);
  endtask

  task automatic read_check(input int unsigned a, input logic [23:0] e);
    rdAddr = a[5:0];
    tick(1);
    check("rdData", rdData, e);
  endtask

  // Sends send_q as one frame plus `extra` trailing bits; gap_a/gap_b select
  // bits whose preceding edge spacing is LATCH-1 / LATCH cycles.
  task automatic run_frame(input int unsigned extra, input logic [23:0] xv,
                           input int gap_a, input int gap_b);
    int unsigned n = send_q.size();
    int bi = 0;
    fr_t f;
    for (int unsigned i = 0; i < n; i++) begin
      exp_px.push_back('{val: send_q[i], idx: (i < LEDS) ? i : LEDS - 1});
      if (i < LEDS) mdl_buf[i] = send_q[i];
    end
    f.len  = (n < LEDS) ? n : LEDS;
    f.part = (extra != 0);
    f.ovf  = (n > LEDS);
    exp_fr.push_back(f);
    for (int unsigned i = 0; i < n; i++)
      for (int b = 23; b >= 0; b--) begin
        send_bit(send_q[i][b], (bi == gap_a) ? LATCH - 5 : (bi == gap_b) ? LATCH - 4 : 4);
        bi++;
      end
    for (int unsigned b = 0; b < extra; b++) send_bit(xv[23 - b], 4);
    clkIn = 1'b0;
    tick(LATCH + 20);
    for (int unsigned i = 0; i < f.len; i++) read_check(i, mdl_buf[i]);
    send_q.delete();
  endtask

  task automatic reset_checks();
    check("rst pixel", pixel, 0);
    check("rst pixelIdx", pixelIdx, 0);
    check("rst pixel_v", pixel_v, 0);
    check("rst frameDone", frameDone, 0);
    check("rst frameLen", frameLen, 0);
    check("rst partialErr", partialErr, 0);
    check("rst overflowErr", overflowErr, 0);
    check("rst busy", busy, 0);
    check("rst rdData", rdData, 0);
  endtask

  always @(negedge clk) begin
    if (pixel_v) begin
      check("pixel_v expected", exp_px.size() != 0, 1);
      if (exp_px.size() != 0) begin
        ep = exp_px.pop_front();
        check("pixel", pixel, ep.val);
        check("pixelIdx", pixelIdx, ep.idx);
      end
    end
    if (frameDone) begin
      check("frameDone expected", exp_fr.size() != 0, 1);
      if (exp_fr.size() != 0) begin
        ef = exp_fr.pop_front();
        check("frameLen", frameLen, ef.len);
        check("partialErr", partialErr, ef.part);
        check("overflowErr", overflowErr, ef.ovf);
      end
    end
  end

  initial begin
    logic [23:0] rv;
    int unsigned n, extra;

    rst = 1'b1; tick(4);
    reset_checks();
    rst = 1'b0; tick(10);

    send_q = '{24'hFFFFFF, 24'hF0F0F0, 24'hAAAAAA};
    run_frame(0, '0, -1, -1);
    read_check(1, 24'hF0F0F0);

    repeat (52) send_q.push_back(24'h123456);
    run_frame(0, '0, -1, -1);

    rv = 24'($urandom);
    send_q.push_back(rv);
    rv = 24'($urandom);
    run_frame(6, rv, -1, -1);
    send_q.push_back(24'($urandom));
    run_frame(0, '0, -1, -1);

    for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(0, 1)), 4);
    clkIn = 1'b0; rst = 1'b1; tick(3);
    reset_checks();
    rst = 1'b0; tick(10);
    send_q.push_back(24'h00FF00);
    run_frame(0, '0, -1, -1);

    rst = 1'b1; clkIn = 1'b1; tick(3);
    rst = 1'b0; tick(20);
    check("busy with clkIn held high", busy, 0);
    send_q.push_back(24'($urandom));
    run_frame(0, '0, -1, -1);

    send_q.push_back(24'($urandom));
    run_frame(0, '0, 5, 13);

    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 8);
      for (int unsigned i = 0; i < n; i++) send_q.push_back(24'($urandom));
      extra = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 23) : 0;
      rv = 24'($urandom);
      run_frame(extra, rv, -1, -1);
    end

    tick(20);
    check("pixels outstanding", exp_px.size(), 0);
    check("frames outstanding", exp_fr.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
